// File: rtl/adder3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder3_rr_arbiter
// Purpose  : Round-robin arbiter sharing one registered three-operand adder
//            among NUM_REQ requesters, with a tag pipeline that routes each
//            sum back to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module adder3_rr_arbiter #(
  parameter  int IN_WIDTH = 10,
  parameter  int NUM_REQ  = 4,
  localparam int TAG_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_I0,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_I1,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_I2,
  output logic                         adder_enable,
  output logic                         adder_inReady,
  output logic [IN_WIDTH-1:0]          adder_I0,
  output logic [IN_WIDTH-1:0]          adder_I1,
  output logic [IN_WIDTH-1:0]          adder_I2,
  input  logic                         adder_outReady,
  input  logic [IN_WIDTH+1:0]          adder_out,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [IN_WIDTH+1:0]          resp_data,
  output logic [TAG_W-1:0]             resp_tag,
  output logic                         busy,
  output logic                         err
);

  // Round-robin pointer: search for the next grant starts here
  logic [TAG_W-1:0]    rr_ptr;

  // Issue register feeding the adder's operand/strobe inputs
  logic                iss_valid;
  logic [TAG_W-1:0]    iss_tag;
  logic [IN_WIDTH-1:0] iss_I0;
  logic [IN_WIDTH-1:0] iss_I1;
  logic [IN_WIDTH-1:0] iss_I2;

  // Tag stage aligned with the adder's single register stage
  logic                t1_valid;
  logic [TAG_W-1:0]    t1_tag;

  // Grant decode results
  logic [TAG_W-1:0]    grant_idx;
  logic                grant_any;
  logic [TAG_W:0]      cand;

  // Per-requester operand views of the flattened buses
  logic [IN_WIDTH-1:0] op0 [NUM_REQ];
  logic [IN_WIDTH-1:0] op1 [NUM_REQ];
  logic [IN_WIDTH-1:0] op2 [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op0[i] = req_I0[i*IN_WIDTH +: IN_WIDTH];
    assign op1[i] = req_I1[i*IN_WIDTH +: IN_WIDTH];
    assign op2[i] = req_I2[i*IN_WIDTH +: IN_WIDTH];
  end

  // Grant: first requesting index at or after rr_ptr, wrapping upward.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (enable) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        cand = {1'b0, rr_ptr} + (TAG_W+1)'(off);
        if (cand >= (TAG_W+1)'(NUM_REQ)) begin
          cand = cand - (TAG_W+1)'(NUM_REQ);
        end
        if (req_valid[cand[TAG_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[TAG_W-1:0];
        end
      end
      if (grant_any) begin
        req_ready[grant_idx] = 1'b1;
      end
    end
  end

  // Issue register, pointer, tag stage and sticky error; all frozen when enable is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      iss_I0    <= '0;
      iss_I1    <= '0;
      iss_I2    <= '0;
      t1_valid  <= 1'b0;
      t1_tag    <= '0;
      err       <= 1'b0;
    end else if (enable) begin
      if (grant_any) begin
        iss_valid <= 1'b1;
        iss_tag   <= grant_idx;
        iss_I0    <= op0[grant_idx];
        iss_I1    <= op1[grant_idx];
        iss_I2    <= op2[grant_idx];
        rr_ptr    <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        iss_valid <= 1'b0;
      end
      t1_valid <= iss_valid;
      t1_tag   <= iss_tag;
      if (adder_outReady != t1_valid) begin
        err <= 1'b1;
      end
    end
  end

  // Response steering: one-hot strobe to the owner of the current sum
  always_comb begin
    resp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      resp_valid[k] = enable & adder_outReady & t1_valid & (t1_tag == TAG_W'(k));
    end
  end

  assign adder_enable  = enable;
  assign adder_inReady = iss_valid;
  assign adder_I0      = iss_I0;
  assign adder_I1      = iss_I1;
  assign adder_I2      = iss_I2;
  assign resp_data     = adder_out;
  assign resp_tag      = t1_tag;
  assign busy          = iss_valid | t1_valid;

endmodule
`default_nettype wire
